// File: rtl/divxx_pkg.sv
// divxx: shared types for the iterative fixed-point divider.
// State encoding and iteration-counter sizing.
package divxx_pkg;

  localparam int DIVXX_W = 18;
  localparam int CNT_W   = $clog2(2*DIVXX_W+1);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_e;

endpackage

// File: rtl/divxx_step.sv
// divxx_step: one restoring shift-subtract iteration.
// Shifts a numerator bit into the partial remainder and trial-subtracts.
module divxx_step #(
  parameter int W = 18
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   sh;
  logic [W+1:0] diff;
  logic         unused_hi;

  assign sh   = {rem_i, bit_i};
  assign diff = {1'b0, sh} - {2'b00, div_i};
  assign q_o  = ~diff[W+1];
  // a kept remainder is always below the divisor, so the top bits are dead
  assign rem_o = q_o ? diff[W-1:0] : sh[W-1:0];
  assign unused_hi = ^{diff[W], sh[W]};

endmodule

// File: rtl/divxx_seq.sv
// divxx_seq: quotient = (r0 << shift) / r1 and remainder, one bit per clock.
// Fixed latency; results and flags are held until the next done.
module divxx_seq
  import divxx_pkg::*;
#(
  parameter int WORD_SIZE = DIVXX_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] r0,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [4:0]           shift,
  input  logic                 signx,
  input  logic                 signy,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] quot,
  output logic [WORD_SIZE-1:0] rem,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int W  = WORD_SIZE;
  localparam int NW = 2*W;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NW-1);
  localparam logic [4:0]       SHMAX = 5'(W-1);
  localparam logic [NW-1:0]    HALF  = NW'(1) << (W-1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [4:0]       sh_q, sh_d;
  logic             sx_q, sx_d;
  logic             sy_q, sy_d;
  logic [NW-1:0]    num_q, num_d;
  logic [W-1:0]     dv_q, dv_d;
  logic [W-1:0]     pr_q, pr_d;
  logic             xneg_q, xneg_d;
  logic             qneg_q, qneg_d;
  logic             sgn_q, sgn_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             dzo_q, dzo_d;
  logic             ovf_q, ovf_d;

  logic             xn, yn;
  logic [NW-1:0]    ext, sft;
  logic [4:0]       shv;
  logic [W-1:0]     st_rem;
  logic             st_q;

  divxx_step #(.W(W)) u_step (
    .rem_i (pr_q),
    .bit_i (num_q[NW-1]),
    .div_i (dv_q),
    .rem_o (st_rem),
    .q_o   (st_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    num_d   = num_q;
    dv_d    = dv_q;
    pr_d    = pr_q;
    xneg_d  = xneg_q;
    qneg_d  = qneg_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    ovf_d   = ovf_q;
    xn      = sx_q & a_q[W-1];
    yn      = sy_q & b_q[W-1];
    ext     = sx_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    shv     = (sh_q > SHMAX) ? SHMAX : sh_q;
    sft     = ext << shv;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = r0;
          b_d     = r1;
          sh_d    = shift;
          sx_d    = signx;
          sy_d    = signy;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        num_d   = xn ? -sft : sft;
        dv_d    = yn ? -b_q : b_q;
        pr_d    = '0;
        cnt_d   = '0;
        xneg_d  = xn;
        qneg_d  = xn ^ yn;
        sgn_d   = sx_q | sy_q;
        dz_d    = (b_q == '0);
        state_d = RUN;
      end
      RUN: begin
        // quotient bits fill the numerator register from the bottom
        num_d = {num_q[NW-2:0], st_q};
        pr_d  = st_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          if (!sgn_q)      quot_d = '1;
          else if (xneg_q) quot_d = {1'b1, {(W-1){1'b0}}};
          else             quot_d = {1'b0, {(W-1){1'b1}}};
          rem_d = a_q;
          ovf_d = 1'b0;
        end else begin
          quot_d = qneg_q ? -num_q[W-1:0] : num_q[W-1:0];
          rem_d  = xneg_q ? -pr_q : pr_q;
          if (!sgn_q)      ovf_d = |num_q[NW-1:W];
          else if (qneg_q) ovf_d = num_q > HALF;
          else             ovf_d = num_q >= HALF;
        end
        dzo_d   = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      num_q   <= '0;
      dv_q    <= '0;
      pr_q    <= '0;
      xneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      num_q   <= num_d;
      dv_q    <= dv_d;
      pr_q    <= pr_d;
      xneg_q  <= xneg_d;
      qneg_q  <= qneg_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dzo_q;
  assign overflow = ovf_q;

endmodule

// File: doc/divxx_seq.md
Name: divxx_seq

Overview:
- Iterative fixed-point divider for the 18-bit datapath; the arithmetic inverse of the combinational multiply-and-shift unit.
- Computes quotient = (r0 << shift) / r1 and the matching remainder.
- Operand signedness is selected per operand. The core produces one quotient bit per clock.
- Sits beside the multiplier in the execute stage. The core stalls on busy and collects results on done.

Parameters:
- WORD_SIZE, 18, operand/result width; internal numerator is 2*WORD_SIZE bits.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- r0  in  WORD_SIZE  dividend
- r1  in  WORD_SIZE  divisor
- shift  in  5  left pre-shift of dividend, 0..17; values >17 behave as 17
- signx  in  1  r0 is two's complement
- signy  in  1  r1 is two's complement
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; results valid
- quot  out  WORD_SIZE  quotient, low WORD_SIZE bits
- rem  out  WORD_SIZE  remainder
- div_zero  out  1  r1 was zero
- overflow  out  1  true quotient does not fit result format

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared. Reset mid-operation aborts immediately with no done.
- States:
  - IDLE: start=1 captures r0, r1, shift, signx, signy, then goes to PREP.
  - PREP: 1 cycle. Forms the 36-bit numerator: r0, sign-extended if signx, else zero-extended, then shifted left by shift. Takes absolute values. Records result signs and the div_zero condition.
  - RUN: exactly 2*WORD_SIZE cycles of restoring shift-subtract, one quotient bit per cycle, MSB first.
  - FIX: 1 cycle. Negates quotient if operand signs differ. Negates remainder if dividend is negative. Computes flags, then returns to IDLE.
- Latency: fixed. done=1 in the cycle following 2*WORD_SIZE+3 rising edges after the start-sampling edge (39 for WORD_SIZE=18), independent of data, including divide-by-zero.
- busy:
  - Rises on the edge that samples start.
  - Falls on the same edge that done rises.
  - start during busy=1 is ignored.
  - start in the done cycle is accepted (back-to-back).
- quot/rem/flags hold until the next done; they do not change during the next operation.
- Arithmetic:
  - Truncation toward zero; remainder carries the dividend's sign.
  - Result is signed if signx|signy, else unsigned.
  - An unsigned operand is always non-negative.
- overflow: the full quotient is outside [0, 2^W-1] when unsigned, or [-2^(W-1), 2^(W-1)-1] when signed. quot still reports the low W bits, with no saturation.
- Divide by zero (r1=0):
  - div_zero=1, overflow=0, rem=r0.
  - quot = all-ones if unsigned.
  - If signed: 2^(W-1)-1 for a non-negative dividend, -2^(W-1) for a negative one.

Decomposition:
- Package divxx_pkg: state enum (IDLE, PREP, RUN, FIX), iteration-counter width localparam ($clog2(2*WORD_SIZE+1)).
- One combinational sub-module divxx_step: trial subtract of the partial remainder vs divisor; outputs next partial remainder and quotient bit.
- Sign handling and the FSM stay in divxx_seq.

Test Plan:
- Unsigned basic: r0=100, r1=7, shift=0, signx=signy=0 -> quot=14, rem=2, no flags. done exactly 39 cycles after start; busy high throughout.
- Fixed-point: r0=1, r1=3, shift=16, unsigned -> quot=0x05555, rem=1.
- Signed: r0=0x3FFF9 (-7), r1=2, signx=signy=1 -> quot=0x3FFFD (-3), rem=0x3FFFF (-1). Also r0=7, r1=0x3FFFE (-2) -> quot=0x3FFFD, rem=1.
- Divide by zero:
  - r0=5, r1=0, unsigned -> quot=0x3FFFF, rem=5, div_zero=1, overflow=0.
  - r0=0x3FFFB, r1=0, signed -> quot=0x20000, rem=0x3FFFB, div_zero=1, overflow=0.
- Overflow:
  - Signed r0=0x20000, r1=0x3FFFF -> quot=0x20000, overflow=1.
  - Unsigned r0=0x3FFFF, r1=1, shift=1 -> quot=0x3FFFE, overflow=1.
- Control:
  - start pulsed mid-run is ignored.
  - start in the done cycle starts a second op; its done arrives 39 cycles later.
  - reset_n low at RUN cycle 10 -> all outputs 0, no done. A new start afterwards completes correctly.
